// File: rtl/aes_mixcolumns_iter.sv
// Iterative AES MixColumns engine, COLS_PER_CYCLE columns per clock.
// Define AES_INV_MIXCOL_EN to build the per-transaction InvMixColumns path.
module aes_mixcolumns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NUM_STEPS = 4 / COLS_PER_CYCLE;

  if (!(COLS_PER_CYCLE == 1 ||
        COLS_PER_CYCLE == 2 ||
        COLS_PER_CYCLE == 4)) begin : g_bad_cfg
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } st_e;

  st_e          st_q, st_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] data_q, data_d;
  logic         inv_q;

  function automatic logic [7:0] xt(
    input logic [7:0] x
  );
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(
    input logic [31:0] c
  );
    logic [7:0] a [4];
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      m2[i] = xt(a[i]);
      m3[i] = m2[i] ^ a[i];
    end
    return {m2[0] ^ m3[1] ^ a[2]  ^ a[3],
            a[0]  ^ m2[1] ^ m3[2] ^ a[3],
            a[0]  ^ a[1]  ^ m2[2] ^ m3[3],
            m3[0] ^ a[1]  ^ a[2]  ^ m2[3]};
  endfunction

`ifdef AES_INV_MIXCOL_EN
  function automatic logic [31:0] mix_inv(
    input logic [31:0] c
  );
    logic [7:0] a [4];
    logic [7:0] x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  logic inv_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inv_q <= 1'b0;
    else        inv_q <= inv_d;
  end
`else
  logic unused_inv;
  assign unused_inv = in_inv;
  assign inv_q      = 1'b0;
`endif

  logic [31:0] cols [4];
  logic [31:0] cols_nx [4];
  logic [127:0] data_nx;

  for (genvar i = 0; i < 4; i++) begin : g_unpack
    assign cols[i]                 = data_q[127-32*i -: 32];
    assign data_nx[127-32*i -: 32] = cols_nx[i];
  end

  // Only the slots of the current group are rewritten.
  always_comb begin
    logic [1:0]  idx;
    logic [31:0] res;
    cols_nx = cols;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      idx = 2'(int'(cnt_q) * COLS_PER_CYCLE + j);
      res = mix_fwd(cols[idx]);
`ifdef AES_INV_MIXCOL_EN
      if (inv_q) res = mix_inv(cols[idx]);
`endif
      cols_nx[idx] = res;
    end
  end

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
`ifdef AES_INV_MIXCOL_EN
    inv_d     = inv_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (st_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      BUSY: begin
        busy   = 1'b1;
        data_d = data_nx;
        if (cnt_q == 2'(NUM_STEPS - 1)) begin
          st_d  = DONE;
          cnt_d = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
    if (in_valid && in_ready) begin
      st_d   = BUSY;
      cnt_d  = 2'd0;
      data_d = in_state;
`ifdef AES_INV_MIXCOL_EN
      inv_d  = in_inv;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      cnt_q  <= 2'd0;
      data_q <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

  assign out_state = data_q;

endmodule

// File: tb/tb_aes_mixcolumns_iter.sv
// Self-checking bench: one DUT per COLS_PER_CYCLE in {1,2,4}.
// Directed table vectors plus backpressure, reset and streaming sequences.
module tb_aes_mixcolumns_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   iv, ir, inv, ov, ord, bsy;
  logic [127:0] ist [3];
  logic [127:0] ost [3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_mixcolumns_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in_inv    (inv[g]),
      .in_state  (ist[g]),
      .out_valid (ov[g]),
      .out_ready (ord[g]),
      .out_state (ost[g]),
      .busy      (bsy[g])
    );
  end

`ifdef AES_INV_MIXCOL_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s,
                                         input logic iv_m);
    logic [7:0]   c [4];
    logic [7:0]   a [4];
    logic [7:0]   r;
    logic [127:0] o = '0;
    if (iv_m && INV_EN) begin
      c[0] = 8'h0e; c[1] = 8'h0b; c[2] = 8'h0d; c[3] = 8'h09;
    end else begin
      c[0] = 8'h02; c[1] = 8'h03; c[2] = 8'h01; c[3] = 8'h01;
    end
    for (int col = 0; col < 4; col++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127-32*col-8*j -: 8];
      for (int i = 0; i < 4; i++) begin
        r = 8'h00;
        for (int j = 0; j < 4; j++) r ^= gm(a[j], c[(j - i) & 3]);
        o[127-32*col-8*i -: 8] = r;
      end
    end
    return o;
  endfunction

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at the sample point right after the input handshake edge.
  task automatic wait_result(input int k, input logic [127:0] exp,
                             input int lat, input string nm);
    int got = 0;
    int bc  = bsy[k] ? 1 : 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (ov[k]) begin
        got = c;
        break;
      end
      if (bsy[k]) bc++;
    end
    check({nm, "_latency"}, 128'(got), 128'(lat));
    check({nm, "_busy_cycles"}, 128'(bc), 128'(lat));
    check({nm, "_state"}, ost[k], exp);
  endtask

  task automatic txn(input int k, input logic iv_v,
                     input logic [127:0] din, input logic [127:0] dout,
                     input int lat, input string nm);
    check({nm, "_in_ready"}, 128'(ir[k]), 128'(1));
    iv[k] = 1'b1; ist[k] = din; inv[k] = iv_v;
    @(posedge clk); #1;
    iv[k] = 1'b0; inv[k] = 1'b0;
    wait_result(k, dout, lat, nm);
  endtask

  typedef struct {
    int           k;
    logic         inv;
    logic [127:0] din;
    logic [127:0] dout;
    int           lat;
  } vec_t;

  localparam logic [127:0] S_A = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] R_A = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] S_B = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] R_B = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

  initial begin
    vec_t         vt [6];
    logic [127:0] held;
    logic [127:0] ss [8];
    logic         sm [8];
    logic [127:0] ex [8];
    int           nst, sent, got, last, cyc;
    logic         hs_in, hs_out;

    vt[0] = '{0, 1'b0, S_A, R_A, 4};
    vt[1] = '{2, 1'b0, S_B, R_B, 1};
    vt[2] = '{1, 1'b1, R_A, INV_EN ? S_A : model(R_A, 1'b0), 2};
    vt[3] = '{1, 1'b0, S_B, R_B, 2};
    vt[4] = '{2, 1'b1, R_B, INV_EN ? S_B : model(R_B, 1'b0), 1};
    vt[5] = '{0, 1'b1, R_A, INV_EN ? S_A : model(R_A, 1'b0), 4};

    rst_n = 1'b0; iv = '0; inv = '0; ord = '1;
    for (int k = 0; k < 3; k++) ist[k] = '0;
    #3;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst%0d_in_ready", k), 128'(ir[k]), 128'(1));
      check($sformatf("rst%0d_out_valid", k), 128'(ov[k]), 128'(0));
      check($sformatf("rst%0d_busy", k), 128'(bsy[k]), 128'(0));
      check($sformatf("rst%0d_out_state", k), ost[k], '0);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      txn(vt[i].k, vt[i].inv, vt[i].din, vt[i].dout, vt[i].lat,
          $sformatf("vec%0d", i));
      @(posedge clk); #1;
    end

    // Backpressure on the 1-column engine, then simultaneous handshakes.
    ord[0] = 1'b0;
    txn(0, 1'b0, S_A, R_A, 4, "bp_first");
    held = ost[0];
    iv[0] = 1'b1; ist[0] = S_B; inv[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_state", c), ost[0], held);
      check($sformatf("bp_hold%0d_in_ready", c), 128'(ir[0]), 128'(0));
      check($sformatf("bp_hold%0d_valid", c), 128'(ov[0]), 128'(1));
      check($sformatf("bp_hold%0d_busy", c), 128'(bsy[0]), 128'(0));
    end
    ord[0] = 1'b1;
    #1;
    check("bp_comb_in_ready", 128'(ir[0]), 128'(1));
    @(posedge clk); #1;
    iv[0] = 1'b0;
    check("bp_swap_valid", 128'(ov[0]), 128'(0));
    check("bp_swap_busy", 128'(bsy[0]), 128'(1));
    wait_result(0, R_B, 4, "bp_second");
    @(posedge clk); #1;

    // Reset during the second BUSY cycle.
    iv[0] = 1'b1; ist[0] = S_A; inv[0] = 1'b0;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    check("rstmid_busy_before", 128'(bsy[0]), 128'(1));
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", 128'(ov[0]), 128'(0));
    check("rstmid_busy", 128'(bsy[0]), 128'(0));
    check("rstmid_state", ost[0], '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rstmid_in_ready", 128'(ir[0]), 128'(1));
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check($sformatf("rstmid_stale%0d", c), 128'(ov[0]), 128'(0));
    end

    // Back-to-back streams with out_ready held high.
    for (int k = 0; k < 3; k++) begin
      nst = 4 >> k;
      for (int i = 0; i < 8; i++) begin
        ss[i] = {$urandom, $urandom, $urandom, $urandom};
        sm[i] = 1'($urandom_range(0, 1));
        ex[i] = model(ss[i], sm[i]);
      end
      sent = 0; got = 0; last = 0; cyc = 0;
      iv[k] = 1'b1; ist[k] = ss[0]; inv[k] = sm[0];
      while (got < 8 && cyc < 200) begin
        hs_in  = iv[k] & ir[k];
        hs_out = ov[k] & ord[k];
        if (hs_out) begin
          check($sformatf("str%0d_res%0d", k, got), ost[k], ex[got]);
          if (got > 0)
            check($sformatf("str%0d_gap%0d", k, got),
                  128'(cyc - last), 128'(nst + 1));
          last = cyc;
          got++;
        end
        @(posedge clk); #1;
        cyc++;
        if (hs_in) begin
          sent++;
          if (sent < 8) begin
            ist[k] = ss[sent]; inv[k] = sm[sent];
          end else begin
            iv[k] = 1'b0; inv[k] = 1'b0;
          end
        end
      end
      check($sformatf("str%0d_count", k), 128'(got), 128'(8));
      iv[k] = 1'b0;
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
